// File: rtl/uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// UART transmit engine at the reader end of the TX FIFO. It pops one word
// at a time (active-low fifo_rdb strobe), waits out the FIFO read latency,
// then serialises the word onto tx:
//   start bit, 7 or 8 data bits LSB first, optional parity, one stop bit.
// Each bit is OVERSAMPLE baud_en pulses long.
//
// When the FIFO still holds data at the end of a stop bit, the next pop is
// issued in that same cycle. Frames then follow each other with only
// FIFO_RD_LAT idle-high clocks between them.
//
// Optional build macro: UART_TX_BREAK_EN
//   When defined, the tx_break input is added. While tx_break=1:
//     - tx is held low;
//     - the current frame still runs to completion internally;
//     - no new pop is issued.
//
// Ports:
//   CLK         system clock, rising edge
//   RESET_N     asynchronous active-low reset
//   baud_en     one-CLK pulse at 16x bit rate
//   bit8        1 = 8 data bits, 0 = 7 data bits (word bit 7 ignored)
//   parity_en   1 = append parity bit
//   odd_n_even  1 = odd parity, 0 = even parity
//   fifo_empty  TX FIFO empty flag
//   fifo_data   TX FIFO read data
//   tx_break    (UART_TX_BREAK_EN only) force line low / hold off pops
//   fifo_rdb    active-low pop strobe to the FIFO
//   tx          serial line, idle high
//   tx_busy     high from the pop until the end of the stop bit
//   tx_done     one-CLK pulse at the end of each stop bit
// ---------------------------------------------------------------------------
module uart_tx_fifo_drain #(
  parameter int FIFO_RD_LAT = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       baud_en,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
`ifdef UART_TX_BREAK_EN
  input  logic       tx_break,
`endif
  output logic       fifo_rdb,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int WW = (FIFO_RD_LAT > 1) ? $clog2(FIFO_RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [WW-1:0]   wait_cnt;
  logic [3:0]      tick;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            parity_acc;
  logic            cfg_bit8;
  logic            cfg_parity;
  logic            cfg_odd;

  logic            brk;
  logic            in_bit;
  logic            bit_end;
  logic            load;
  logic            tx_fsm;

`ifdef UART_TX_BREAK_EN
  assign brk = tx_break;
`else
  assign brk = 1'b0;
`endif

  // The tick counter only runs while a bit is on the line; in IDLE/WAIT it
  // is held at 0 so that START always begins a full bit period.
  assign in_bit  = (state == S_START) || (state == S_DATA) ||
                   (state == S_PARITY) || (state == S_STOP);
  assign bit_end = in_bit && baud_en && (tick == 4'(OVERSAMPLE - 1));

  // ---------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    fifo_rdb   = 1'b1;
    tx_done    = 1'b0;
    tx_fsm     = 1'b1;
    load       = 1'b0;

    case (state)
      S_IDLE: begin
        // Pop is combinational on !fifo_empty, so it can never fire on an
        // empty FIFO. Leaving IDLE at once also keeps it to a single cycle.
        if (!fifo_empty && !brk) begin
          fifo_rdb   = 1'b0;
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wait_cnt == WW'(FIFO_RD_LAT - 1)) begin
          load       = 1'b1;
          state_next = S_START;
        end
      end

      S_START: begin
        tx_fsm = 1'b0;
        if (bit_end) begin
          state_next = S_DATA;
        end
      end

      S_DATA: begin
        tx_fsm = shift_reg[0];
        if (bit_end && (bit_cnt == (cfg_bit8 ? 3'd7 : 3'd6))) begin
          state_next = cfg_parity ? S_PARITY : S_STOP;
        end
      end

      S_PARITY: begin
        tx_fsm = parity_acc ^ cfg_odd;
        if (bit_end) begin
          state_next = S_STOP;
        end
      end

      S_STOP: begin
        tx_fsm = 1'b1;
        if (bit_end) begin
          tx_done = 1'b1;
          // Chain straight into the next word when one is waiting.
          if (!fifo_empty && !brk) begin
            fifo_rdb   = 1'b0;
            state_next = S_WAIT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      default: begin
        tx_fsm     = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  // The line is decoded from state, so an asynchronous reset to IDLE
  // returns tx high immediately.
  assign tx      = brk ? 1'b0 : tx_fsm;
  assign tx_busy = (state == S_WAIT) || in_bit;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Counters and datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_cnt   <= '0;
      tick       <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_acc <= 1'b0;
      cfg_bit8   <= 1'b0;
      cfg_parity <= 1'b0;
      cfg_odd    <= 1'b0;
    end else begin
      // FIFO read latency counter
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      // Oversample tick counter
      if (in_bit) begin
        if (baud_en) begin
          tick <= bit_end ? 4'd0 : tick + 4'd1;
        end
      end else begin
        tick <= '0;
      end

      // Word capture: the FIFO output is valid in the last WAIT cycle.
      // Frame format is frozen here, so later config changes cannot
      // corrupt a frame already in flight.
      if (load) begin
        shift_reg  <= fifo_data;
        bit_cnt    <= '0;
        parity_acc <= 1'b0;
        cfg_bit8   <= bit8;
        cfg_parity <= parity_en;
        cfg_odd    <= odd_n_even;
      end else if ((state == S_DATA) && bit_end) begin
        shift_reg  <= {1'b0, shift_reg[7:1]};
        parity_acc <= parity_acc ^ shift_reg[0];
        bit_cnt    <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
module tb_uart_tx_fifo_drain;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_en = 1'b0;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
`ifdef UART_TX_BREAK_EN
  logic       tx_break = 1'b0;
`endif
  logic       fifo_rdb;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int tests = 0;
  int fails = 0;

  // Monitor counters (written only by the negedge monitor)
  int   pops = 0;
  int   done_cnt = 0;
  int   pop_in_done = 0;
  int   rdb_viol = 0;
  logic rdb_prev = 1'b1;
  logic pop_now = 1'b0;

  // FIFO model state
  logic [7:0] q[$];
  logic [7:0] stage = 8'h00;

  uart_tx_fifo_drain dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .baud_en    (baud_en),
    .bit8       (bit8),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
`ifdef UART_TX_BREAK_EN
    .tx_break   (tx_break),
`endif
    .fifo_rdb   (fifo_rdb),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // baud_en: one pulse every 4 clocks, changed 2 ns after the rising edge
  initial begin
    int bc;
    bc = 0;
    forever begin
      @(posedge clk);
      #2;
      bc = (bc + 1) % 4;
      baud_en = (bc == 0);
    end
  end

  // FIFO model: pop sampled mid-cycle, two-stage read pipeline
  initial begin
    forever begin
      @(posedge clk);
      #1;
      fifo_data = stage;
      if (pop_now && (q.size() > 0)) stage = q.pop_front();
      fifo_empty = (q.size() == 0);
    end
  end

  // Mid-cycle monitor of strobes
  always @(negedge clk) begin
    pop_now = !fifo_rdb;
    if (!fifo_rdb) begin
      pops = pops + 1;
      if (fifo_empty) rdb_viol = rdb_viol + 1;
      if (!rdb_prev) rdb_viol = rdb_viol + 1;
      if (tx_done) pop_in_done = pop_in_done + 1;
    end
    rdb_prev = fifo_rdb;
    if (tx_done) done_cnt = done_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %b required %b", tag, obs, req);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  // Wait for n baud_en pulses, return 1 ns after the last one's edge
  task automatic wait_baud(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (baud_en) c++;
    end
    #1;
  endtask

  // Wait (bounded) for the start bit; edges = clocks waited
  task automatic wait_start(input string nm, output int edges);
    edges = 0;
    while ((tx !== 1'b0) && (edges < 400)) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk1({nm, "_start"}, tx, 1'b0);
  endtask

  // Check a whole frame bit by bit, starting right after the start edge
  task automatic check_frame(input logic [7:0] d, input int nd, input logic par_on,
                             input logic par_bit, input string nm);
    logic bits[12];
    int   nb;
    int   d0;
    d0 = done_cnt;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < nd; i++) begin
      bits[nb] = d[i]; nb++;
    end
    if (par_on) begin
      bits[nb] = par_bit; nb++;
    end
    bits[nb] = 1'b1; nb++;
    for (int i = 0; i < nb; i++) begin
      wait_baud(8);
      chk1($sformatf("%s_b%0d_mid", nm, i), tx, bits[i]);
      wait_baud(7);
      chk1($sformatf("%s_b%0d_late", nm, i), tx, bits[i]);
      wait_baud(1);
    end
    chkn({nm, "_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int   e;
    int   p0;
    int   pd0;
    logic ok;

    // ---- Reset values
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_rdb", fifo_rdb, 1'b1);
    chk1("rst_busy", tx_busy, 1'b0);
    chk1("rst_done", tx_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Idle with empty FIFO for 1000 baud pulses
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wait_baud(1);
      if (tx !== 1'b1 || fifo_rdb !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    chk1("idle_quiet", ok, 1'b1);
    chkn("idle_pops", pops, 0);

    // ---- 0xA5, 8 bits, no parity
    q.push_back(8'hA5);
    wait_start("a5", e);
    chkn("a5_pops", pops, 1);
    chk1("a5_busy", tx_busy, 1'b1);
    check_frame(8'hA5, 8, 1'b0, 1'b0, "a5");
    repeat (2) @(posedge clk);
    #1;
    chk1("a5_busy_end", tx_busy, 1'b0);
    chkn("a5_pops_end", pops, 1);

    // ---- 0x37 with even parity (five ones -> parity 1), then odd (-> 0)
    parity_en = 1'b1;
    odd_n_even = 1'b0;
    q.push_back(8'h37);
    wait_start("p_even", e);
    check_frame(8'h37, 8, 1'b1, 1'b1, "p_even");
    odd_n_even = 1'b1;
    q.push_back(8'h37);
    wait_start("p_odd", e);
    check_frame(8'h37, 8, 1'b1, 1'b0, "p_odd");

    // ---- 7-bit word 0xFF, no parity: 9 bit times
    parity_en = 1'b0;
    odd_n_even = 1'b0;
    bit8 = 1'b0;
    q.push_back(8'hFF);
    wait_start("b7", e);
    check_frame(8'hFF, 7, 1'b0, 1'b0, "b7");
    repeat (20) @(posedge clk);
    #1;
    chk1("b7_idle_tx", tx, 1'b1);
    chk1("b7_idle_busy", tx_busy, 1'b0);
    bit8 = 1'b1;

    // ---- Back-to-back 0x01, 0x02, 0x03
    p0 = pops;
    pd0 = pop_in_done;
    q.push_back(8'h01);
    q.push_back(8'h02);
    q.push_back(8'h03);
    wait_start("bb1", e);
    check_frame(8'h01, 8, 1'b0, 1'b0, "bb1");
    wait_start("bb2", e);
    chkn("bb2_gap", e, 2);
    check_frame(8'h02, 8, 1'b0, 1'b0, "bb2");
    wait_start("bb3", e);
    chkn("bb3_gap", e, 2);
    check_frame(8'h03, 8, 1'b0, 1'b0, "bb3");
    chkn("bb_pops", pops - p0, 3);
    chkn("bb_pop_in_done", pop_in_done - pd0, 2);
    chkn("rdb_violations", rdb_viol, 0);

    // ---- Reset in the middle of data bit 1 of 0x55 (a 0 on the line)
    q.push_back(8'h55);
    wait_start("r55", e);
    wait_baud(40);
    chk1("r55_pre_tx", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("r55_rst_tx", tx, 1'b1);
    chk1("r55_rst_busy", tx_busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pops;
    repeat (200) @(posedge clk);
    #1;
    chkn("r55_no_pop", pops - p0, 0);
    chk1("r55_tx_idle", tx, 1'b1);

`ifdef UART_TX_BREAK_EN
    // ---- Break for 40 bit times with a word waiting
    tx_break = 1'b1;
    p0 = pops;
    q.push_back(8'h5A);
    ok = 1'b1;
    for (int i = 0; i < 40 * 16; i++) begin
      wait_baud(1);
      if (tx !== 1'b0) ok = 1'b0;
    end
    chk1("brk_low", ok, 1'b1);
    chkn("brk_no_pop", pops - p0, 0);
    tx_break = 1'b0;
    @(posedge clk);
    #1;
    wait_start("brk_resume", e);
    check_frame(8'h5A, 8, 1'b0, 1'b0, "brk_resume");
    chkn("brk_pops", pops - p0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
